// File: rtl/cheri_regfile_mp.sv
// Multi-port CHERI capability register file with per-register reservation counters,
// tag revocation and optional write/revocation bypass on the read ports.

package cheri_regfile_mp_pkg;
  typedef struct packed {
    logic       valid;
    logic [4:0] exp;
    logic [8:0] top;
    logic [8:0] base;
    logic [5:0] perms;
  } reg_cap_t;

  parameter reg_cap_t NULL_REG_CAP = '0;
endpackage

module cheri_regfile_mp
  import cheri_regfile_mp_pkg::*;
#(
  parameter int unsigned NREGS      = 32,
  parameter int unsigned NCAPS      = 32,
  parameter int unsigned NRPORTS    = 2,
  parameter int unsigned NWPORTS    = 2,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned MaxRsv     = 3,
  parameter bit          TRVKBypass = 1'b1,
  parameter bit          WrBypass   = 1'b0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NRPORTS*5-1:0]           raddr_i,
  output logic [NRPORTS*DataWidth-1:0]   rdata_o,
  output reg_cap_t [NRPORTS-1:0]         rcap_o,
  input  logic [NWPORTS*5-1:0]           waddr_i,
  input  logic [NWPORTS*DataWidth-1:0]   wdata_i,
  input  reg_cap_t [NWPORTS-1:0]         wcap_i,
  input  logic [NWPORTS-1:0]             we_i,
  input  logic [4:0]                     trsv_addr_i,
  input  logic                           trsv_en_i,
  input  logic [4:0]                     trvk_addr_i,
  input  logic                           trvk_en_i,
  input  logic                           trvk_clrtag_i,
  output logic [31:0]                    reg_rdy_o,
  output logic                           rsv_ovf_o,
  output logic                           rvk_unf_o,
  output logic                           wr_conflict_o
);

  localparam int unsigned CW = $clog2(MaxRsv + 1);

  logic [DataWidth-1:0] data_q [NREGS];
  logic [DataWidth-1:0] data_d [NREGS];
  reg_cap_t             cap_q  [NCAPS];
  reg_cap_t             cap_d  [NCAPS];
  logic [CW-1:0]        cnt_q  [NCAPS];
  logic [CW-1:0]        cnt_d  [NCAPS];

  logic rsv_ovf_q, rsv_ovf_d;
  logic rvk_unf_q, rvk_unf_d;
  logic wr_conflict_q, wr_conflict_d;

  logic [NCAPS-1:0] rsv_hit, rvk_hit, clr_hit;

  // Only registers 1..NCAPS-1 take part in reservation and revocation.
  always_comb begin
    rsv_hit = '0;
    rvk_hit = '0;
    clr_hit = '0;
    for (int unsigned i = 1; i < NCAPS; i++) begin
      rsv_hit[i] = trsv_en_i && (32'(trsv_addr_i) == i);
      rvk_hit[i] = trvk_en_i && (32'(trvk_addr_i) == i);
      clr_hit[i] = rvk_hit[i] && trvk_clrtag_i;
    end
  end

  always_comb begin
    logic [4:0] wa;
    data_d = data_q;
    cap_d  = cap_q;
    // Ascending port order lets the higher-index port win on an address clash.
    for (int unsigned p = 0; p < NWPORTS; p++) begin
      wa = waddr_i[p*5 +: 5];
      if (we_i[p] && (wa != 5'd0)) begin
        if (32'(wa) < NREGS) data_d[wa] = wdata_i[p*DataWidth +: DataWidth];
        if (32'(wa) < NCAPS) cap_d[wa]  = wcap_i[p];
      end
    end
    for (int unsigned i = 1; i < NCAPS; i++) begin
      if (clr_hit[i]) cap_d[i].valid = 1'b0;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    rsv_ovf_d = 1'b0;
    rvk_unf_d = 1'b0;
    for (int unsigned i = 1; i < NCAPS; i++) begin
      if (rsv_hit[i] && !rvk_hit[i]) begin
        if (cnt_q[i] == CW'(MaxRsv)) rsv_ovf_d = 1'b1;
        else                         cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (rvk_hit[i] && !rsv_hit[i]) begin
        if (cnt_q[i] == '0) rvk_unf_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_comb begin
    wr_conflict_d = 1'b0;
    for (int unsigned p = 0; p < NWPORTS; p++) begin
      for (int unsigned q = p + 1; q < NWPORTS; q++) begin
        if (we_i[p] && we_i[q] && (waddr_i[p*5 +: 5] == waddr_i[q*5 +: 5]) &&
            (waddr_i[p*5 +: 5] != 5'd0)) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREGS; i++) data_q[i] <= '0;
      for (int unsigned i = 0; i < NCAPS; i++) begin
        cap_q[i] <= NULL_REG_CAP;
        cnt_q[i] <= '0;
      end
      rsv_ovf_q     <= 1'b0;
      rvk_unf_q     <= 1'b0;
      wr_conflict_q <= 1'b0;
    end else begin
      data_q        <= data_d;
      cap_q         <= cap_d;
      cnt_q         <= cnt_d;
      rsv_ovf_q     <= rsv_ovf_d;
      rvk_unf_q     <= rvk_unf_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  always_comb begin
    logic [4:0]           ra;
    logic [4:0]           wa;
    logic [DataWidth-1:0] rd;
    reg_cap_t             rc;
    rdata_o = '0;
    rcap_o  = '0;
    for (int unsigned p = 0; p < NRPORTS; p++) begin
      ra = raddr_i[p*5 +: 5];
      rd = '0;
      rc = NULL_REG_CAP;
      if ((ra != 5'd0) && (32'(ra) < NREGS)) rd = data_q[ra];
      if ((ra != 5'd0) && (32'(ra) < NCAPS)) rc = cap_q[ra];
      if (WrBypass) begin
        for (int unsigned w = 0; w < NWPORTS; w++) begin
          wa = waddr_i[w*5 +: 5];
          if (we_i[w] && (wa != 5'd0) && (wa == ra) && (32'(ra) < NREGS)) begin
            rd = wdata_i[w*DataWidth +: DataWidth];
            rc = (32'(ra) < NCAPS) ? wcap_i[w] : NULL_REG_CAP;
          end
        end
      end
      // Revocation outranks both the stored tag and any forwarded write tag.
      if (TRVKBypass && (ra != 5'd0) && (32'(ra) < NCAPS) && clr_hit[ra]) rc.valid = 1'b0;
      rdata_o[p*DataWidth +: DataWidth] = rd;
      rcap_o[p] = rc;
    end
  end

  always_comb begin
    reg_rdy_o = '1;
    for (int unsigned i = 1; i < 32; i++) begin
      if (i < NCAPS) begin
        reg_rdy_o[i] = (cnt_q[i] == '0) ||
                       (TRVKBypass && (cnt_q[i] == CW'(1)) && rvk_hit[i] && !rsv_hit[i]);
      end
    end
  end

  assign rsv_ovf_o     = rsv_ovf_q;
  assign rvk_unf_o     = rvk_unf_q;
  assign wr_conflict_o = wr_conflict_q;

endmodule

// File: tb/tb_cheri_regfile_mp.sv
// Directed self-checking bench for cheri_regfile_mp; a second instance with write bypass
// enabled shares all inputs so forwarding can be compared against the registered path.

module tb_cheri_regfile_mp;
  import cheri_regfile_mp_pkg::*;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [9:0]      raddr_i;
  logic [63:0]     rdata_o, rdata_b;
  reg_cap_t [1:0]  rcap_o, rcap_b;
  logic [9:0]      waddr_i;
  logic [63:0]     wdata_i;
  reg_cap_t [1:0]  wcap_i;
  logic [1:0]      we_i;
  logic [4:0]      trsv_addr_i, trvk_addr_i;
  logic            trsv_en_i, trvk_en_i, trvk_clrtag_i;
  logic [31:0]     reg_rdy_o, reg_rdy_b;
  logic            rsv_ovf_o, rvk_unf_o, wr_conflict_o;
  logic            rsv_ovf_b, rvk_unf_b, wr_conflict_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cheri_regfile_mp #(.WrBypass(1'b0)) dut (
    .clk_i(clk), .rst_i(rst_i), .raddr_i(raddr_i), .rdata_o(rdata_o), .rcap_o(rcap_o),
    .waddr_i(waddr_i), .wdata_i(wdata_i), .wcap_i(wcap_i), .we_i(we_i),
    .trsv_addr_i(trsv_addr_i), .trsv_en_i(trsv_en_i), .trvk_addr_i(trvk_addr_i),
    .trvk_en_i(trvk_en_i), .trvk_clrtag_i(trvk_clrtag_i), .reg_rdy_o(reg_rdy_o),
    .rsv_ovf_o(rsv_ovf_o), .rvk_unf_o(rvk_unf_o), .wr_conflict_o(wr_conflict_o)
  );

  cheri_regfile_mp #(.WrBypass(1'b1)) dut_byp (
    .clk_i(clk), .rst_i(rst_i), .raddr_i(raddr_i), .rdata_o(rdata_b), .rcap_o(rcap_b),
    .waddr_i(waddr_i), .wdata_i(wdata_i), .wcap_i(wcap_i), .we_i(we_i),
    .trsv_addr_i(trsv_addr_i), .trsv_en_i(trsv_en_i), .trvk_addr_i(trvk_addr_i),
    .trvk_en_i(trvk_en_i), .trvk_clrtag_i(trvk_clrtag_i), .reg_rdy_o(reg_rdy_b),
    .rsv_ovf_o(rsv_ovf_b), .rvk_unf_o(rvk_unf_b), .wr_conflict_o(wr_conflict_b)
  );

  task automatic idle();
    we_i = '0; waddr_i = '0; wdata_i = '0; wcap_i = '0;
    trsv_en_i = 1'b0; trvk_en_i = 1'b0; trvk_clrtag_i = 1'b0;
    trsv_addr_i = '0; trvk_addr_i = '0;
  endtask

  // Advance past the next rising edge; inputs change 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; raddr_i = '0; idle();
    step(); step();
    rst_i = 1'b0;
    for (int a = 0; a < 32; a++) begin
      raddr_i = {5'(a), 5'(a)};
      #1;
      n_checks++;
      if (rdata_o !== 64'd0 || rcap_o !== {NULL_REG_CAP, NULL_REG_CAP}) begin
        n_fail++;
        $display("FAIL reset_read a=%0d data=%h cap=%h required 0", a, rdata_o, rcap_o);
      end
    end
    n_checks++;
    if (reg_rdy_o !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL reset_rdy got %h required ffffffff", reg_rdy_o);
    end
    n_checks++;
    if ({rsv_ovf_o, rvk_unf_o, wr_conflict_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got %b required 000", {rsv_ovf_o, rvk_unf_o, wr_conflict_o});
    end
  endtask

  task automatic test_write_conflict();
    we_i = 2'b11; waddr_i = {5'd5, 5'd5}; wdata_i = {32'h0000_ABCD, 32'h0000_1234};
    step();
    idle(); raddr_i = {5'd0, 5'd5};
    #1;
    n_checks++;
    if (rdata_o[31:0] !== 32'h0000_ABCD) begin
      n_fail++; $display("FAIL conflict_winner got %h required 0000abcd", rdata_o[31:0]);
    end
    n_checks++;
    if (wr_conflict_o !== 1'b1) begin
      n_fail++; $display("FAIL conflict_flag got %b required 1", wr_conflict_o);
    end
    step();
    n_checks++;
    if (wr_conflict_o !== 1'b0) begin
      n_fail++; $display("FAIL conflict_pulse got %b required 0", wr_conflict_o);
    end
    we_i = 2'b11; waddr_i = '0; wdata_i = {32'h0000_ABCD, 32'h0000_1234};
    step();
    idle(); raddr_i = '0;
    #1;
    n_checks++;
    if (wr_conflict_o !== 1'b0 || rdata_o !== 64'd0) begin
      n_fail++;
      $display("FAIL conflict_x0 flag=%b data=%h required 0/0", wr_conflict_o, rdata_o);
    end
  endtask

  task automatic test_reservation();
    trsv_addr_i = 5'd7; trsv_en_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if (reg_rdy_o[7] !== 1'b0 || rsv_ovf_o !== (k == 4)) begin
        n_fail++;
        $display("FAIL rsv_%0d rdy7=%b ovf=%b required 0/%b", k, reg_rdy_o[7], rsv_ovf_o, k == 4);
      end
    end
    idle();
    step();
    n_checks++;
    if (rsv_ovf_o !== 1'b0) begin
      n_fail++; $display("FAIL rsv_ovf_pulse got %b required 0", rsv_ovf_o);
    end
    trvk_addr_i = 5'd7; trvk_en_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (reg_rdy_o[7] !== (k == 3)) begin
        n_fail++; $display("FAIL rvk_%0d rdy7=%b required %b", k, reg_rdy_o[7], k == 3);
      end
      step();
    end
    n_checks++;
    if (rvk_unf_o !== 1'b0) begin
      n_fail++; $display("FAIL rvk_no_unf got %b required 0", rvk_unf_o);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (rvk_unf_o !== 1'b1 || reg_rdy_o[7] !== 1'b1) begin
      n_fail++; $display("FAIL rvk_unf got %b rdy7=%b required 1/1", rvk_unf_o, reg_rdy_o[7]);
    end
    step();
    n_checks++;
    if (rvk_unf_o !== 1'b0) begin
      n_fail++; $display("FAIL rvk_unf_pulse got %b required 0", rvk_unf_o);
    end
  endtask

  task automatic test_tag_clear();
    reg_cap_t c1, c2, exp_c;
    c1 = '{valid: 1'b1, exp: 5'd3, top: 9'h1A5, base: 9'h042, perms: 6'h2B};
    c2 = '{valid: 1'b1, exp: 5'd7, top: 9'h0F0, base: 9'h011, perms: 6'h15};
    we_i = 2'b01; waddr_i = {5'd0, 5'd9}; wdata_i = {32'd0, 32'h0000_5555}; wcap_i = {c1, c1};
    step();
    idle(); raddr_i = {5'd9, 5'd0};
    #1;
    n_checks++;
    if (rdata_o[63:32] !== 32'h0000_5555 || rcap_o[1] !== c1) begin
      n_fail++;
      $display("FAIL tag_store data=%h cap=%h required 00005555/%h", rdata_o[63:32], rcap_o[1], c1);
    end
    we_i = 2'b01; waddr_i = {5'd0, 5'd9}; wdata_i = {32'd0, 32'h0000_7777}; wcap_i = {c1, c2};
    trvk_addr_i = 5'd9; trvk_en_i = 1'b1; trvk_clrtag_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rcap_o[1].valid !== 1'b0 || rdata_o[63:32] !== 32'h0000_5555) begin
      n_fail++;
      $display("FAIL tag_bypass valid=%b data=%h required 0/00005555",
               rcap_o[1].valid, rdata_o[63:32]);
    end
    exp_c = c2; exp_c.valid = 1'b0;
    n_checks++;
    if (rcap_b[1] !== exp_c || rdata_b[63:32] !== 32'h0000_7777) begin
      n_fail++;
      $display("FAIL tag_fwd cap=%h data=%h required %h/00007777", rcap_b[1], rdata_b[63:32], exp_c);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (rdata_o[63:32] !== 32'h0000_7777 || rcap_o[1] !== exp_c) begin
      n_fail++;
      $display("FAIL tag_after data=%h cap=%h required 00007777/%h", rdata_o[63:32], rcap_o[1], exp_c);
    end
    n_checks++;
    if (rvk_unf_o !== 1'b1) begin
      n_fail++; $display("FAIL tag_unf got %b required 1", rvk_unf_o);
    end
  endtask

  task automatic test_wr_bypass();
    we_i = 2'b01; waddr_i = {5'd0, 5'd3}; wdata_i = {32'd0, 32'hDEAD};
    raddr_i = {5'd3, 5'd0};
    @(negedge clk);
    n_checks++;
    if (rdata_b[63:32] !== 32'h0000_DEAD) begin
      n_fail++; $display("FAIL byp_fwd got %h required 0000dead", rdata_b[63:32]);
    end
    n_checks++;
    if (rdata_o[63:32] !== 32'd0) begin
      n_fail++; $display("FAIL byp_old got %h required 00000000", rdata_o[63:32]);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (rdata_o[63:32] !== 32'h0000_DEAD) begin
      n_fail++; $display("FAIL byp_next got %h required 0000dead", rdata_o[63:32]);
    end
  endtask

  task automatic test_reset_mid();
    we_i = 2'b01; waddr_i = {5'd0, 5'd4}; wdata_i = {32'd0, 32'h44};
    trsv_addr_i = 5'd4; trsv_en_i = 1'b1;
    step();
    we_i = '0;
    step();
    idle(); raddr_i = {5'd0, 5'd4};
    #1;
    n_checks++;
    if (reg_rdy_o[4] !== 1'b0 || rdata_o[31:0] !== 32'h44) begin
      n_fail++;
      $display("FAIL mid_pre rdy4=%b data=%h required 0/00000044", reg_rdy_o[4], rdata_o[31:0]);
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (reg_rdy_o[4] !== 1'b1 || rdata_o[31:0] !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_rst rdy4=%b data=%h required 1/00000000", reg_rdy_o[4], rdata_o[31:0]);
    end
    trsv_addr_i = 5'd4; trsv_en_i = 1'b1; trvk_addr_i = 5'd4; trvk_en_i = 1'b1;
    step();
    idle();
    #1;
    n_checks++;
    if (reg_rdy_o[4] !== 1'b1 || rsv_ovf_o !== 1'b0 || rvk_unf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_both rdy4=%b ovf=%b unf=%b required 1/0/0",
               reg_rdy_o[4], rsv_ovf_o, rvk_unf_o);
    end
    // A lone release now must underflow, proving the counter stayed at zero.
    trvk_addr_i = 5'd4; trvk_en_i = 1'b1;
    step();
    idle();
    #1;
    n_checks++;
    if (rvk_unf_o !== 1'b1) begin
      n_fail++; $display("FAIL mid_cnt0 unf=%b required 1", rvk_unf_o);
    end
  endtask

  initial begin
    test_reset();
    test_write_conflict();
    test_reservation();
    test_tag_clear();
    test_wr_bypass();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
